// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the two-client add/subtract arbiter.
package arbitro_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef logic [0:0] client_t;

    localparam client_t CLIENT0 = 1'b0;
    localparam client_t CLIENT1 = 1'b1;

    // On a tie the client that was not granted last wins.
    function automatic client_t pick_winner(input logic r0, input logic r1, input client_t last);
        client_t w;
        if (r0 && r1) begin
            w = client_t'(~last);
        end else if (r0) begin
            w = CLIENT0;
        end else begin
            w = CLIENT1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sumador_restador_w.sv
// Combinational WIDTH-bit adder/subtractor; subtract is A + ~B + 1, so c is NOT borrow.
module sumador_restador_w #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    logic [WIDTH:0] sum_s;

    assign sum_s = {1'b0, a} + {1'b0, b ^ {WIDTH{op}}} + {{WIDTH{1'b0}}, op};
    assign {c, s} = sum_s;

endmodule

// File: rtl/arbitro_sumador_restador.sv
// Round-robin scheduler sharing one adder/subtractor between two clients,
// with per-client registered results held until acknowledged.
module arbitro_sumador_restador
    import arbitro_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             op0,
    input  logic             op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             vld0,
    output logic             vld1,
    output logic [WIDTH-1:0] res0,
    output logic [WIDTH-1:0] res1,
    output logic             c0,
    output logic             c1,
    input  logic             ack0,
    input  logic             ack1
);

    state_t           state_r, state_nxt_s;
    client_t          last_gnt_r, win_r, gsel_s;
    logic             op_r;
    logic [WIDTH-1:0] a_r, b_r, sum_s;
    logic             carry_s, ack_win_s;
    logic             grant_s, load_s, clear_s;
    logic             gnt0_r, gnt1_r, vld0_r, vld1_r, c0_r, c1_r;
    logic [WIDTH-1:0] res0_r, res1_r;

    assign gsel_s = pick_winner(req0, req1, last_gnt_r);

    sumador_restador_w #(.WIDTH(WIDTH)) u_dp (
        .a  (a_r),
        .b  (b_r),
        .op (op_r),
        .s  (sum_s),
        .c  (carry_s)
    );

    // Only the current winner's ack can release HOLD.
    always_comb begin
        if (win_r == CLIENT0) begin
            ack_win_s = ack0;
        end else begin
            ack_win_s = ack1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: state_nxt_s = HOLD;
            HOLD: begin
                if (ack_win_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        grant_s = 1'b0;
        load_s  = 1'b0;
        clear_s = 1'b0;
        case (state_r)
            IDLE:    grant_s = req0 || req1;
            CALC:    load_s  = 1'b1;
            HOLD:    clear_s = ack_win_s;
            default: grant_s = 1'b0;
        endcase
    end

    // Operand capture, winner and round-robin pointer, all updated only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r       <= 1'b0;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            win_r      <= CLIENT0;
            last_gnt_r <= CLIENT1;
        end else if (grant_s) begin
            if (gsel_s == CLIENT0) begin
                op_r <= op0;
                a_r  <= a0;
                b_r  <= b0;
            end else begin
                op_r <= op1;
                a_r  <= a1;
                b_r  <= b1;
            end
            win_r      <= gsel_s;
            last_gnt_r <= gsel_s;
        end else begin
            op_r       <= op_r;
            a_r        <= a_r;
            b_r        <= b_r;
            win_r      <= win_r;
            last_gnt_r <= last_gnt_r;
        end
    end

    // One-cycle grant pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
        end else begin
            gnt0_r <= grant_s && (gsel_s == CLIENT0);
            gnt1_r <= grant_s && (gsel_s == CLIENT1);
        end
    end

    // Client 0 result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld0_r <= 1'b0;
            res0_r <= {WIDTH{1'b0}};
            c0_r   <= 1'b0;
        end else if (load_s && (win_r == CLIENT0)) begin
            vld0_r <= 1'b1;
            res0_r <= sum_s;
            c0_r   <= carry_s;
        end else if (clear_s && (win_r == CLIENT0)) begin
            vld0_r <= 1'b0;
        end else begin
            vld0_r <= vld0_r;
        end
    end

    // Client 1 result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_r <= 1'b0;
            res1_r <= {WIDTH{1'b0}};
            c1_r   <= 1'b0;
        end else if (load_s && (win_r == CLIENT1)) begin
            vld1_r <= 1'b1;
            res1_r <= sum_s;
            c1_r   <= carry_s;
        end else if (clear_s && (win_r == CLIENT1)) begin
            vld1_r <= 1'b0;
        end else begin
            vld1_r <= vld1_r;
        end
    end

    assign gnt0 = gnt0_r;
    assign gnt1 = gnt1_r;
    assign vld0 = vld0_r;
    assign vld1 = vld1_r;
    assign res0 = res0_r;
    assign res1 = res1_r;
    assign c0   = c0_r;
    assign c1   = c1_r;

endmodule
